satatrn_txdma: RTL and testbench

Transport-layer write-DMA sequencer. Accepts a host-to-device transfer length in dwords, waits for each DMA Activate from the device, and streams source dwords to the transmit arbiter's data port as one or more Data FIS payloads of at most MAX_FIS_DWORDS each. It drives the arbiter's txgate, marks each payload end with o_last, waits for link-layer R_OK/R_ERR per FIS, and reports completion or error to the command layer.

---
 rtl/satatrn_txdma_pkg.sv | 23 ++
 rtl/satatrn_txdma_if.sv | 29 ++
 rtl/satatrn_txdma_oreg.sv | 70 +++++++
 rtl/satatrn_txdma.sv | 176 +++++++++++++++++
 tb/tb_satatrn_txdma.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/satatrn_txdma_pkg.sv
// -----------------------------------------------------------------------------
// satatrn_txdma_pkg
// Shared SATA transport-layer definitions. The transmit arbiter and the
// receive-side DMA Activate decoder use these too. Holds the Data FIS type
// code, the default payload limit and the write-DMA sequencer state encoding.
// -----------------------------------------------------------------------------
package satatrn_txdma_pkg;

   // FIS type code of a Data FIS (host-to-device or device-to-host payload).
   localparam logic [7:0] FIS_DATA = 8'h46;

   // Largest Data FIS payload in dwords (8 KiB).
   localparam int MAX_FIS_DWORDS_DEF = 2048;

   // Write-DMA sequencer states. The 2-bit encoding is shared with the arbiter.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACT = 2'd1,
      ST_SEND     = 2'd2,
      ST_WAIT_ACK = 2'd3
   } txdma_state_e;

endpackage

// File: rtl/satatrn_txdma_if.sv
// -----------------------------------------------------------------------------
// satatrn_txdma_if
// Data path bundle of the write-DMA sequencer. It carries two streams:
//   source stream  : s_valid, s_ready, s_data (no last flag)
//   payload stream : o_valid, i_ready, o_data, o_last, plus o_txgate
// master : the DMA sequencer. It consumes the source and drives the payload.
// slave  : the environment. It supplies the source and takes the payload
//          (source FIFO plus transmit arbiter).
// -----------------------------------------------------------------------------
interface satatrn_txdma_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        o_txgate;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic        o_last;

   modport master (
      input  s_valid, s_data, i_ready,
      output s_ready, o_txgate, o_valid, o_data, o_last
   );

   modport slave (
      output s_valid, s_data, i_ready,
      input  s_ready, o_txgate, o_valid, o_data, o_last
   );
endinterface

// File: rtl/satatrn_txdma_oreg.sv
// -----------------------------------------------------------------------------
// satatrn_txdma_oreg
// Single-entry output register for the payload stream. It loads a new word
// when it is empty or when its current word is being taken
// (!o_valid || i_ready). It holds the word otherwise.
// Ports:
//   i_clk, i_reset_n      : clock, synchronous active-low reset
//   i_load, i_data, i_last: word offered this cycle (used only if o_can_load)
//   o_can_load            : register can take a word this cycle
//   o_valid, o_data, o_last, i_ready : downstream handshake
// OPT_LOWPOWER zeroes o_data when no word is held.
// o_last is always cleared when no word is held.
// -----------------------------------------------------------------------------
module satatrn_txdma_oreg #(
   parameter bit OPT_LOWPOWER = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_load,
   input  logic [31:0] i_data,
   input  logic        i_last,
   output logic        o_can_load,
   output logic        o_valid,
   output logic [31:0] o_data,
   output logic        o_last,
   input  logic        i_ready
);

   logic        valid_q, valid_d;
   logic [31:0] data_q,  data_d;
   logic        last_q,  last_d;

   assign o_can_load = !valid_q || i_ready;

   // NOTE: every next-state variable gets a default first so that no path
   // leaves it unassigned; a missing default in always_comb infers a latch.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (o_can_load) begin
         valid_d = i_load;
         last_d  = i_load && i_last;
         if (i_load) begin
            data_d = i_data;
         end else if (OPT_LOWPOWER) begin
            data_d = '0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_last  = last_q;

endmodule

// File: rtl/satatrn_txdma.sv
// -----------------------------------------------------------------------------
// satatrn_txdma
// Transport-layer write-DMA sequencer. It accepts a transfer length in dwords
// and waits for each DMA Activate. For each one it streams up to
// MAX_FIS_DWORDS source dwords to the arbiter as one Data FIS payload, then
// waits for the link result (R_OK/R_ERR). It reports completion or error.
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_start, i_len   : start request and length (sampled in IDLE only)
//   i_abort          : abort request (deferred to frame end while sending)
//   o_busy           : state is not IDLE
//   o_done, o_err    : registered one-cycle completion pulses
//   i_dma_activate   : device DMA Activate received
//   i_fis_ok/err     : link result of the last transmitted FIS
//   dbus             : source stream, payload stream and txgate
// -----------------------------------------------------------------------------
module satatrn_txdma
   import satatrn_txdma_pkg::*;
#(
   parameter int LGLEN          = 24,
   parameter int MAX_FIS_DWORDS = MAX_FIS_DWORDS_DEF,
   parameter bit OPT_LOWPOWER   = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [LGLEN-1:0] i_len,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   input  logic             i_dma_activate,
   input  logic             i_fis_ok,
   input  logic             i_fis_err,
   satatrn_txdma_if.master  dbus
);

   localparam int              IW        = $clog2(MAX_FIS_DWORDS) + 1;
   localparam logic [LGLEN-1:0] MAX_LEN   = LGLEN'(MAX_FIS_DWORDS);
   localparam logic [IW-1:0]    MAX_ISSUE = IW'(MAX_FIS_DWORDS);

   txdma_state_e     state_q, state_d;
   logic [LGLEN-1:0] remaining_q, remaining_d;  // dwords not yet taken from source
   logic [IW-1:0]    issue_q, issue_d;          // dwords still to take in this frame
   logic             abort_q, abort_d;          // abort seen while sending
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic          can_load;
   logic          src_ready;
   logic          src_fire;
   logic          last_accept;
   logic          abort_pend;
   logic [IW-1:0] frame_len;

   // The source is accepted only when the output register can take the word,
   // so no word is ever held inside this block between the two streams.
   assign src_ready   = (state_q == ST_SEND) && can_load && (issue_q != '0);
   assign src_fire    = src_ready && dbus.s_valid;
   assign last_accept = dbus.o_valid && dbus.i_ready && dbus.o_last;
   assign abort_pend  = abort_q || i_abort;
   assign frame_len   = (remaining_q >= MAX_LEN) ? MAX_ISSUE : IW'(remaining_q);

   satatrn_txdma_oreg #(
      .OPT_LOWPOWER (OPT_LOWPOWER)
   ) u_oreg (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (src_fire),
      .i_data     (dbus.s_data),
      .i_last     (issue_q == IW'(1)),
      .o_can_load (can_load),
      .o_valid    (dbus.o_valid),
      .o_data     (dbus.o_data),
      .o_last     (dbus.o_last),
      .i_ready    (dbus.i_ready)
   );

   // State and counter registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         issue_q     <= '0;
         abort_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         issue_q     <= issue_d;
         abort_q     <= abort_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next-state, counter and completion-pulse logic.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      issue_d     = issue_q;
      abort_d     = abort_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (i_start) begin
               if (i_len != '0) begin
                  remaining_d = i_len;
                  state_d     = ST_WAIT_ACT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_WAIT_ACT: begin
            if (i_abort) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (i_dma_activate) begin
               issue_d = frame_len;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (src_fire) begin
               // src_fire implies issue_q != 0. remaining_q is at least
               // issue_q, so neither counter can wrap.
               issue_d = issue_q - 1'b1;
               if (remaining_q != '0) begin
                  remaining_d = remaining_q - 1'b1;
               end
            end
            // An abort during a frame is held until its last word leaves.
            // The frame then ends at full length, and the ack is not awaited.
            abort_d = abort_pend;
            if (last_accept) begin
               abort_d = 1'b0;
               if (abort_pend) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT_ACK;
               end
            end
         end
         ST_WAIT_ACK: begin
            // R_ERR wins over a simultaneous R_OK.
            if (i_fis_err || i_abort) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (i_fis_ok) begin
               if (remaining_q == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT_ACT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      o_busy        = (state_q != ST_IDLE);
      dbus.o_txgate = (state_q == ST_SEND);
      dbus.s_ready  = src_ready;
      o_done        = done_q;
      o_err         = err_q;
   end

endmodule

// File: tb/tb_satatrn_txdma.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_satatrn_txdma
// Directed bench for the write-DMA sequencer. Stimulus pushes the expected
// payload words and completion events into queues. A monitor on the falling
// edge pops and compares them whenever the DUT presents a word or a pulse.
// -----------------------------------------------------------------------------
module tb_satatrn_txdma;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   localparam logic [1:0] EV_DONE = 2'b10;
   localparam logic [1:0] EV_ERR  = 2'b01;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [23:0] len;
   logic        abort;
   logic        busy, done, err;
   logic        act, fis_ok, fis_err;

   logic        gap_en     = 1'b0;
   logic        ready_rand = 1'b0;

   word_t       exp_q[$];
   logic [31:0] src_q[$];
   logic [1:0]  ev_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   satatrn_txdma_if bus ();

   satatrn_txdma #(
      .LGLEN          (24),
      .MAX_FIS_DWORDS (2048),
      .OPT_LOWPOWER   (1'b0)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_start        (start),
      .i_len          (len),
      .i_abort        (abort),
      .o_busy         (busy),
      .o_done         (done),
      .o_err          (err),
      .i_dma_activate (act),
      .i_fis_ok       (fis_ok),
      .i_fis_err      (fis_err),
      .dbus           (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- source driver ----------------
   initial begin
      logic fire;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      forever begin
         @(negedge clk);
         fire = bus.s_valid && bus.s_ready && rst_n;
         @(posedge clk);
         #1;
         if (fire && src_q.size() > 0) src_q.delete(0);
         if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            bus.s_valid = 1'b1;
            bus.s_data  = src_q[0];
         end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = '0;
         end
      end
   end

   // ---------------- downstream ready driver ----------------
   initial begin
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.i_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic        stall_prev = 1'b0;
      logic [31:0] stall_data = '0;
      logic        stall_last = 1'b0;
      word_t       w;
      logic [1:0]  ev;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("stall_valid_held", bus.o_valid, 1);
               check("stall_data_held", bus.o_data, stall_data);
               check("stall_last_held", bus.o_last, stall_last);
            end
            stall_prev = bus.o_valid && !bus.i_ready;
            stall_data = bus.o_data;
            stall_last = bus.o_last;
            if (bus.o_valid && bus.i_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %0h, expected no word", bus.o_data);
               end else begin
                  w = exp_q.pop_front();
                  check("word_data", bus.o_data, w.data);
                  check("word_last", bus.o_last, w.last);
               end
            end
            if (done || err) begin
               if (ev_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_event: got done=%0b err=%0b, expected none", done, err);
               end else begin
                  ev = ev_q.pop_front();
                  check("event_done_err", {done, err}, ev);
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_xfer(input logic [23:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_act();
      act = 1'b1;
      tick();
      act = 1'b0;
   endtask

   task automatic pulse_ok();
      fis_ok = 1'b1;
      tick();
      fis_ok = 1'b0;
   endtask

   // Queue n source words base+k; frame boundaries every 'frame' words.
   task automatic push_words(input logic [31:0] base, input int n, input int frame);
      word_t w;
      for (int k = 0; k < n; k++) begin
         src_q.push_back(base + 32'(k));
         w.data = base + 32'(k);
         w.last = ((k + 1) % frame == 0) || (k == n - 1);
         exp_q.push_back(w);
      end
   endtask

   // Wait until the expected-word queue shrinks to 'target'; returns cycles used.
   task automatic drain(input string name, input int target, input int budget, output int cycles);
      cycles = 0;
      while (exp_q.size() > target && cycles < budget) begin
         tick();
         cycles++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'(target));
   endtask

   task automatic wait_ev(input string name, input int budget);
      int c = 0;
      while (ev_q.size() != 0 && c < budget) begin
         tick();
         c++;
      end
      check({name, "_event_seen"}, 32'(ev_q.size()), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int c;
      rst_n   = 1'b0;
      start   = 1'b0;
      len     = '0;
      abort   = 1'b0;
      act     = 1'b0;
      fis_ok  = 1'b0;
      fis_err = 1'b0;
      tick(3);

      // Reset values
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_o_last", bus.o_last, 0);
      check("rst_o_data", bus.o_data, 0);
      check("rst_o_txgate", bus.o_txgate, 0);
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_o_busy", busy, 0);
      check("rst_o_done", done, 0);
      check("rst_o_err", err, 0);
      rst_n = 1'b1;
      tick(2);

      // Single 5-word frame
      start_xfer(24'd5);
      check("t1_busy", busy, 1);
      check("t1_txgate_before_act", bus.o_txgate, 0);
      check("t1_s_ready_before_act", bus.s_ready, 0);
      push_words(32'h0000_1000, 5, 5);
      tick();
      pulse_act();
      check("t1_txgate_after_act", bus.o_txgate, 1);
      check("t1_s_ready_after_act", bus.s_ready, 1);
      drain("t1", 0, 50, cyc);
      check("t1_cycles", 32'(cyc), 6);
      check("t1_txgate_after_last", bus.o_txgate, 0);
      check("t1_valid_after_last", bus.o_valid, 0);
      check("t1_busy_wait_ack", busy, 1);
      ev_q.push_back(EV_DONE);
      pulse_ok();
      check("t1_done", done, 1);
      check("t1_busy_idle", busy, 0);
      wait_ev("t1", 5);
      tick();
      check("t1_done_one_cycle", done, 0);

      // Zero length
      ev_q.push_back(EV_DONE);
      start_xfer(24'd0);
      check("t2_done", done, 1);
      check("t2_busy", busy, 0);
      check("t2_txgate", bus.o_txgate, 0);
      tick();
      check("t2_done_one_cycle", done, 0);
      wait_ev("t2", 5);

      // Multi-frame split: 2048 + 2048 + 4
      start_xfer(24'd4100);
      push_words(32'hA000_0000, 4100, 2048);
      tick();
      for (int f = 0; f < 3; f++) begin
         pulse_act();
         check("t3_txgate_on", bus.o_txgate, 1);
         drain("t3_frame", (f == 0) ? 2052 : (f == 1) ? 4 : 0, 2200, cyc);
         check("t3_txgate_off", bus.o_txgate, 0);
         if (f < 2) begin
            pulse_ok();
            check("t3_busy_between", busy, 1);
            check("t3_done_between", done, 0);
            check("t3_s_ready_wait_act", bus.s_ready, 0);
            tick(2);
         end else begin
            ev_q.push_back(EV_DONE);
            pulse_ok();
            check("t3_done", done, 1);
            check("t3_busy_idle", busy, 0);
         end
      end
      wait_ev("t3", 5);
      tick();

      // Backpressure with gapped source
      gap_en     = 1'b1;
      ready_rand = 1'b1;
      start_xfer(24'd20);
      push_words(32'h5A5A_0000, 20, 20);
      tick();
      pulse_act();
      drain("t4", 0, 400, cyc);
      gap_en     = 1'b0;
      ready_rand = 1'b0;
      ev_q.push_back(EV_DONE);
      pulse_ok();
      wait_ev("t4", 5);
      tick();

      // R_ERR together with R_OK after frame 1 of 3
      start_xfer(24'd6000);
      push_words(32'hE000_0000, 2048, 2048);
      tick();
      pulse_act();
      drain("t5", 0, 2200, cyc);
      ev_q.push_back(EV_ERR);
      fis_ok  = 1'b1;
      fis_err = 1'b1;
      tick();
      fis_ok  = 1'b0;
      fis_err = 1'b0;
      check("t5_err", err, 1);
      check("t5_done", done, 0);
      check("t5_busy", busy, 0);
      src_q.push_back(32'hDEAD_BEEF);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t5_no_s_ready", bus.s_ready, 0);
      end
      src_q.delete();
      wait_ev("t5", 5);
      tick(2);

      // Abort during a 100-word frame
      start_xfer(24'd100);
      push_words(32'hB000_0000, 100, 100);
      tick();
      pulse_act();
      c = 0;
      while (exp_q.size() > 90 && c < 50) begin
         tick();
         c++;
      end
      check("t6_reached_word10", 32'(exp_q.size() <= 90), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t6_still_sending", bus.o_txgate, 1);
      ev_q.push_back(EV_ERR);
      drain("t6", 0, 300, cyc);
      check("t6_err", err, 1);
      check("t6_busy", busy, 0);
      check("t6_txgate", bus.o_txgate, 0);
      wait_ev("t6", 5);
      tick();

      // Abort in WAIT_ACT
      start_xfer(24'd8);
      ev_q.push_back(EV_ERR);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t7_err", err, 1);
      check("t7_busy", busy, 0);
      wait_ev("t7", 5);
      tick();

      // Reset mid-frame, then a normal transfer
      start_xfer(24'd50);
      push_words(32'hD000_0000, 50, 50);
      tick();
      pulse_act();
      c = 0;
      while (exp_q.size() > 40 && c < 50) begin
         tick();
         c++;
      end
      check("t8_midframe_valid", bus.o_valid, 1);
      rst_n = 1'b0;
      tick();
      check("t8_rst_valid", bus.o_valid, 0);
      check("t8_rst_last", bus.o_last, 0);
      check("t8_rst_data", bus.o_data, 0);
      check("t8_rst_txgate", bus.o_txgate, 0);
      check("t8_rst_busy", busy, 0);
      check("t8_rst_s_ready", bus.s_ready, 0);
      exp_q.delete();
      src_q.delete();
      tick();
      rst_n = 1'b1;
      tick(2);
      start_xfer(24'd3);
      push_words(32'hF000_0000, 3, 3);
      tick();
      pulse_act();
      drain("t8_after", 0, 50, cyc);
      ev_q.push_back(EV_DONE);
      pulse_ok();
      check("t8_after_done", done, 1);
      wait_ev("t8_after", 5);

      tick(3);
      check("end_words_left", 32'(exp_q.size()), 0);
      check("end_events_left", 32'(ev_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
